// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause
// bit positions and reset constants used by the coprocessor and its picker.
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // Status / Cause bit positions
    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int ST_BEV     = 22;
    localparam int CA_EXC_LO  = 2;
    localparam int CA_IP_LO   = 8;
    localparam int CA_HWIP_LO = 10;
    localparam int CA_IP7     = 15;
    localparam int CA_TI      = 30;
    localparam int CA_BD      = 31;

    localparam logic [31:0] EXC_VEC_DEF = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST  = 32'h0040_0000;

endpackage

// File: rtl/cp0_victim_sel.sv
// Priority picker: chooses the oldest slot that redirects (interrupt on slot 0
// first, then the lowest excepting/ERET slot) and builds the squash mask.
module cp0_victim_sel
    import cp0_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int IDX_W   = 1
) (
    input  logic [ISSUE_W-1:0] slot_valid_i,
    input  logic [ISSUE_W-1:0] slot_exc_i,
    input  logic [ISSUE_W-1:0] slot_eret_i,
    input  logic               intp_i,
    output logic               vic_valid_o,
    output logic [IDX_W-1:0]   vic_idx_o,
    output logic               vic_int_o,
    output logic [ISSUE_W-1:0] flush_mask_o
);

    // Scan youngest to oldest so the oldest candidate is left standing.
    always_comb begin
        vic_valid_o  = 1'b0;
        vic_idx_o    = '0;
        vic_int_o    = 1'b0;
        flush_mask_o = '0;
        for (int i = ISSUE_W - 1; i >= 0; i--) begin
            if (slot_valid_i[i] && (slot_exc_i[i] || slot_eret_i[i])) begin
                vic_valid_o = 1'b1;
                vic_idx_o   = IDX_W'(i);
            end
        end
        if (intp_i && slot_valid_i[0]) begin
            vic_valid_o = 1'b1;
            vic_idx_o   = '0;
            vic_int_o   = 1'b1;
        end
        for (int i = 0; i < ISSUE_W; i++) begin
            flush_mask_o[i] = vic_valid_o && (IDX_W'(i) >= vic_idx_o);
        end
    end

endmodule

// File: rtl/cp0_multi_issue.sv
// Multi-issue CP0: BadVAddr/Count/Compare/Status/Cause/EPC, commit-slot
// exception arbitration, interrupt sampling and flush/redirect generation.
// Optional feature macro: CP0_TIMER_INT_EN (Compare register and timer interrupt).
module cp0_multi_issue
    import cp0_pkg::*;
#(
    parameter int          ISSUE_W   = 2,
    parameter int          HW_INT_N  = 6,
    parameter int          COUNT_DIV = 2,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [HW_INT_N-1:0]     hw_int,
    input  logic [ISSUE_W-1:0]      slot_valid,
    input  logic [ISSUE_W-1:0]      slot_exc,
    input  logic [ISSUE_W*5-1:0]    slot_code,
    input  logic [ISSUE_W-1:0]      slot_eret,
    input  logic [ISSUE_W-1:0]      slot_ds,
    input  logic [ISSUE_W*32-1:0]   slot_pc,
    input  logic [ISSUE_W*32-1:0]   slot_bva,
    input  logic [ISSUE_W-1:0]      slot_we,
    input  logic [ISSUE_W*5-1:0]    slot_waddr,
    input  logic [ISSUE_W*32-1:0]   slot_wdata,
    input  logic [ISSUE_W*5-1:0]    slot_raddr,
    output logic [ISSUE_W*32-1:0]   slot_rdata,
    output logic                    flush,
    output logic [ISSUE_W-1:0]      flush_mask,
    output logic [31:0]             new_pc
);

    localparam int IDX_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [31:0]      badvaddr_q, badvaddr_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      status_q, status_d;
    logic [31:0]      cause_q, cause_d;
    logic [31:0]      epc_q, epc_d;
    logic [DIV_W-1:0] div_q, div_d;
`ifdef CP0_TIMER_INT_EN
    logic [31:0]      compare_q, compare_d;
    logic             cmp_wr;
    logic             ti;
`endif

    logic               intp;
    logic               vic_valid;
    logic [IDX_W-1:0]   vic_idx;
    logic               vic_int;
    logic [ISSUE_W-1:0] vic_mask;
    logic               vic_eret;
    logic               vic_ds;
    logic [4:0]         vic_code;
    logic [31:0]        vic_pc;
    logic [31:0]        vic_bva;
    logic [5:0]         ip_hw;

    assign intp = (|(cause_q[15:8] & status_q[15:8])) & status_q[ST_IE] & ~status_q[ST_EXL];

    cp0_victim_sel #(
        .ISSUE_W (ISSUE_W),
        .IDX_W   (IDX_W)
    ) u_victim_sel (
        .slot_valid_i (slot_valid),
        .slot_exc_i   (slot_exc),
        .slot_eret_i  (slot_eret),
        .intp_i       (intp),
        .vic_valid_o  (vic_valid),
        .vic_idx_o    (vic_idx),
        .vic_int_o    (vic_int),
        .flush_mask_o (vic_mask)
    );

    assign vic_eret = slot_eret[vic_idx] & ~vic_int;
    assign vic_ds   = slot_ds[vic_idx];
    assign vic_code = slot_code[vic_idx*5 +: 5];
    assign vic_pc   = slot_pc[vic_idx*32 +: 32];
    assign vic_bva  = slot_bva[vic_idx*32 +: 32];

    // Redirect outputs and MFC0 reads, all forced quiet while reset is held.
    always_comb begin
        flush      = 1'b0;
        flush_mask = '0;
        new_pc     = '0;
        slot_rdata = '0;
        if (!rst) begin
            flush      = vic_valid;
            flush_mask = vic_mask;
            if (vic_valid) begin
                new_pc = vic_eret ? epc_q : EXC_VEC;
            end
            for (int i = 0; i < ISSUE_W; i++) begin
                case (slot_raddr[i*5 +: 5])
                    CP0_BADVADDR: slot_rdata[i*32 +: 32] = badvaddr_q;
                    CP0_COUNT:    slot_rdata[i*32 +: 32] = count_q;
`ifdef CP0_TIMER_INT_EN
                    CP0_COMPARE:  slot_rdata[i*32 +: 32] = compare_q;
`endif
                    CP0_STATUS:   slot_rdata[i*32 +: 32] = status_q;
                    CP0_CAUSE:    slot_rdata[i*32 +: 32] = cause_q;
                    CP0_EPC:      slot_rdata[i*32 +: 32] = epc_q;
                    default:      slot_rdata[i*32 +: 32] = '0;
                endcase
            end
        end
    end

    // Next-state: timer, MTC0 from slots older than the victim, then exception updates on top.
    always_comb begin
        badvaddr_d = badvaddr_q;
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        if (div_q == DIV_W'(COUNT_DIV - 1)) begin
            div_d   = '0;
            count_d = count_q + 32'd1;
        end else begin
            div_d   = div_q + DIV_W'(1);
            count_d = count_q;
        end
`ifdef CP0_TIMER_INT_EN
        compare_d = compare_q;
        cmp_wr    = 1'b0;
`endif
        for (int i = 0; i < ISSUE_W; i++) begin
            if (slot_valid[i] && slot_we[i] && (!vic_valid || (IDX_W'(i) < vic_idx))) begin
                case (slot_waddr[i*5 +: 5])
                    CP0_COUNT: begin
                        count_d = slot_wdata[i*32 +: 32];
                        div_d   = '0;
                    end
`ifdef CP0_TIMER_INT_EN
                    CP0_COMPARE: begin
                        compare_d = slot_wdata[i*32 +: 32];
                        cmp_wr    = 1'b1;
                    end
`endif
                    CP0_STATUS: status_d = slot_wdata[i*32 +: 32] | STATUS_RST;
                    CP0_CAUSE:  cause_d[CA_IP_LO +: 2] = slot_wdata[i*32 + CA_IP_LO +: 2];
                    CP0_EPC:    epc_d = slot_wdata[i*32 +: 32];
                    default: ;
                endcase
            end
        end
        ip_hw                 = '0;
        ip_hw[HW_INT_N-1:0]   = hw_int;
        cause_d[CA_HWIP_LO +: 6] = ip_hw;
`ifdef CP0_TIMER_INT_EN
        ti = cause_q[CA_TI];
        if (cmp_wr) begin
            ti = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            ti = 1'b1;
        end
        cause_d[CA_TI]  = ti;
        cause_d[CA_IP7] = ti;
`endif
        if (vic_valid) begin
            if (vic_eret) begin
                status_d[ST_EXL] = 1'b0;
            end else begin
                if (!status_q[ST_EXL]) begin
                    epc_d          = vic_ds ? (vic_pc - 32'd4) : vic_pc;
                    cause_d[CA_BD] = vic_ds;
                end
                status_d[ST_EXL]      = 1'b1;
                cause_d[CA_EXC_LO +: 5] = vic_int ? EXC_INT : vic_code;
                if (!vic_int && ((vic_code == EXC_ADEL) || (vic_code == EXC_ADES))) begin
                    badvaddr_d = vic_bva;
                end
            end
        end
    end

    // Register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            status_q   <= STATUS_RST;
            cause_q    <= '0;
            epc_q      <= '0;
            div_q      <= '0;
`ifdef CP0_TIMER_INT_EN
            compare_q  <= '0;
`endif
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            div_q      <= div_d;
`ifdef CP0_TIMER_INT_EN
            compare_q  <= compare_d;
`endif
        end
    end

endmodule

// File: tb/tb_cp0_multi_issue.sv
// Directed testbench for cp0_multi_issue (ISSUE_W=2, HW_INT_N=6, COUNT_DIV=2).
module tb_cp0_multi_issue;
    import cp0_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  hw_int;
    logic [1:0]  slot_valid, slot_exc, slot_eret, slot_ds, slot_we;
    logic [9:0]  slot_code, slot_waddr, slot_raddr;
    logic [63:0] slot_pc, slot_bva, slot_wdata, slot_rdata;
    logic        flush;
    logic [1:0]  flush_mask;
    logic [31:0] new_pc;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    cp0_multi_issue #(
        .ISSUE_W   (2),
        .HW_INT_N  (6),
        .COUNT_DIV (2),
        .EXC_VEC   (32'hBFC0_0380)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hw_int     (hw_int),
        .slot_valid (slot_valid),
        .slot_exc   (slot_exc),
        .slot_code  (slot_code),
        .slot_eret  (slot_eret),
        .slot_ds    (slot_ds),
        .slot_pc    (slot_pc),
        .slot_bva   (slot_bva),
        .slot_we    (slot_we),
        .slot_waddr (slot_waddr),
        .slot_wdata (slot_wdata),
        .slot_raddr (slot_raddr),
        .slot_rdata (slot_rdata),
        .flush      (flush),
        .flush_mask (flush_mask),
        .new_pc     (new_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_slots();
        slot_valid = '0; slot_exc = '0; slot_eret = '0; slot_ds = '0; slot_we = '0;
        slot_code = '0; slot_waddr = '0; slot_raddr = '0;
        slot_pc = '0; slot_bva = '0; slot_wdata = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        clear_slots();
        slot_valid[0] = 1'b1; slot_we[0] = 1'b1; slot_waddr[4:0] = a; slot_wdata[31:0] = d;
        @(posedge clk);
        #1;
        clear_slots();
    endtask

    task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
        slot_raddr[4:0] = a;
        #1;
        d = slot_rdata[31:0];
    endtask

    task automatic test_reset();
        rst = 1'b1; hw_int = '0; clear_slots();
        repeat (2) @(posedge clk);
        @(negedge clk);
        slot_valid = 2'b11; slot_exc = 2'b01; slot_raddr[4:0] = CP0_STATUS;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %0h exp 0", flush); end
        checks++; if (flush_mask !== 2'b00) begin errors++; $display("FAIL rst_mask got %0h exp 0", flush_mask); end
        checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL rst_newpc got %h exp 0", new_pc); end
        checks++; if (slot_rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", slot_rdata); end
        clear_slots();
        rst = 1'b0;
        mfc0(CP0_STATUS, rd);
        checks++; if (rd !== 32'h0040_0000) begin errors++; $display("FAIL rst_status got %h exp 00400000", rd); end
        mfc0(CP0_CAUSE, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_cause got %h exp 0", rd); end
        mfc0(CP0_EPC, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_epc got %h exp 0", rd); end
    endtask

    task automatic test_oldest_exc();
        @(negedge clk);
        clear_slots();
        slot_valid = 2'b11; slot_exc = 2'b11;
        slot_code = {EXC_SYS, EXC_OV};
        slot_pc = {32'hBFC0_1004, 32'hBFC0_1000};
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL t1_flush got %0h exp 1", flush); end
        checks++; if (flush_mask !== 2'b11) begin errors++; $display("FAIL t1_mask got %b exp 11", flush_mask); end
        checks++; if (new_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL t1_newpc got %h exp bfc00380", new_pc); end
        @(posedge clk);
        @(negedge clk);
        clear_slots();
        mfc0(CP0_EPC, rd);
        checks++; if (rd !== 32'hBFC0_1000) begin errors++; $display("FAIL t1_epc got %h exp bfc01000", rd); end
        mfc0(CP0_CAUSE, rd);
        checks++; if (rd !== 32'h0000_0030) begin errors++; $display("FAIL t1_cause got %h exp 00000030", rd); end
        mfc0(CP0_STATUS, rd);
        checks++; if (rd !== 32'h0040_0002) begin errors++; $display("FAIL t1_status got %h exp 00400002", rd); end
        mtc0(CP0_STATUS, 32'h0);
    endtask

    task automatic test_adel_ds();
        @(negedge clk);
        clear_slots();
        slot_valid = 2'b11; slot_exc = 2'b10; slot_ds = 2'b10;
        slot_code = {EXC_ADEL, 5'h00};
        slot_pc = {32'h8000_0104, 32'h8000_0100};
        slot_bva = {32'h8000_0003, 32'h0};
        slot_we = 2'b01; slot_waddr = {5'd0, CP0_EPC}; slot_wdata = {32'h0, 32'h0000_1234};
        #1;
        checks++; if (flush_mask !== 2'b10) begin errors++; $display("FAIL t2_mask got %b exp 10", flush_mask); end
        @(posedge clk);
        @(negedge clk);
        clear_slots();
        mfc0(CP0_EPC, rd);
        checks++; if (rd !== 32'h8000_0100) begin errors++; $display("FAIL t2_epc got %h exp 80000100", rd); end
        mfc0(CP0_CAUSE, rd);
        checks++; if (rd !== 32'h8000_0010) begin errors++; $display("FAIL t2_cause got %h exp 80000010", rd); end
        mfc0(CP0_BADVADDR, rd);
        checks++; if (rd !== 32'h8000_0003) begin errors++; $display("FAIL t2_bva got %h exp 80000003", rd); end
        mtc0(CP0_STATUS, 32'h0);
    endtask

    task automatic test_mtc0();
        @(negedge clk);
        clear_slots();
        slot_valid = 2'b11; slot_we = 2'b11;
        slot_waddr = {CP0_EPC, CP0_EPC}; slot_wdata = {32'h22, 32'h11};
        slot_raddr = {CP0_EPC, 5'd0};
        #1;
        checks++; if (slot_rdata[63:32] !== 32'h8000_0100) begin errors++; $display("FAIL mt_nobypass got %h exp 80000100", slot_rdata[63:32]); end
        @(posedge clk);
        @(negedge clk);
        clear_slots();
        mfc0(CP0_EPC, rd);
        checks++; if (rd !== 32'h22) begin errors++; $display("FAIL mt_highwins got %h exp 00000022", rd); end
        @(negedge clk);
        slot_valid = 2'b11; slot_exc = 2'b10; slot_code = {EXC_SYS, 5'd0};
        slot_pc = {32'h8000_2000, 32'h8000_1ffc};
        slot_we = 2'b01; slot_waddr = {5'd0, CP0_STATUS}; slot_wdata = {32'h0, 32'h0000_FF00};
        @(posedge clk);
        @(negedge clk);
        clear_slots();
        mfc0(CP0_STATUS, rd);
        checks++; if (rd !== 32'h0040_FF02) begin errors++; $display("FAIL mt_older_status got %h exp 0040ff02", rd); end
        mfc0(CP0_EPC, rd);
        checks++; if (rd !== 32'h8000_2000) begin errors++; $display("FAIL mt_sys_epc got %h exp 80002000", rd); end
        mtc0(CP0_STATUS, 32'h0);
        mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
        @(negedge clk);
        mfc0(CP0_CAUSE, rd);
        checks++; if (rd[15:8] !== 8'h03) begin errors++; $display("FAIL mt_cause_ip got %h exp 03", rd[15:8]); end
        mtc0(CP0_BADVADDR, 32'h0000_DEAD);
        @(negedge clk);
        mfc0(CP0_BADVADDR, rd);
        checks++; if (rd !== 32'h8000_0003) begin errors++; $display("FAIL mt_bva_ro got %h exp 80000003", rd); end
        mfc0(5'd5, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mt_unmapped got %h exp 0", rd); end
        mtc0(CP0_CAUSE, 32'h0);
    endtask

    task automatic test_interrupt();
        mtc0(CP0_STATUS, 32'h0000_0401);
        @(negedge clk);
        hw_int = 6'b000001;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL int_noslot got %0h exp 0", flush); end
        slot_valid = 2'b01; slot_exc = 2'b01; slot_code = {5'd0, EXC_OV};
        slot_pc = {32'h0, 32'h8000_1000};
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL int_flush got %0h exp 1", flush); end
        checks++; if (new_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL int_newpc got %h exp bfc00380", new_pc); end
        @(posedge clk);
        @(negedge clk);
        slot_exc = 2'b00;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL int_exl_block got %0h exp 0", flush); end
        clear_slots();
        mfc0(CP0_CAUSE, rd);
        checks++; if (rd[6:2] !== 5'h00) begin errors++; $display("FAIL int_code got %h exp 00", rd[6:2]); end
        mfc0(CP0_EPC, rd);
        checks++; if (rd !== 32'h8000_1000) begin errors++; $display("FAIL int_epc got %h exp 80001000", rd); end
        hw_int = '0;
        mtc0(CP0_STATUS, 32'h0);
    endtask

    task automatic test_eret();
        mtc0(CP0_EPC, 32'hBFC0_2000);
        mtc0(CP0_STATUS, 32'h0000_0002);
        @(negedge clk);
        slot_valid = 2'b11; slot_eret = 2'b01;
        slot_we = 2'b10; slot_waddr = {CP0_EPC, 5'd0}; slot_wdata = {32'hDEAD_0000, 32'h0};
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL eret_flush got %0h exp 1", flush); end
        checks++; if (new_pc !== 32'hBFC0_2000) begin errors++; $display("FAIL eret_newpc got %h exp bfc02000", new_pc); end
        @(posedge clk);
        @(negedge clk);
        clear_slots();
        mfc0(CP0_STATUS, rd);
        checks++; if (rd !== 32'h0040_0000) begin errors++; $display("FAIL eret_status got %h exp 00400000", rd); end
        mfc0(CP0_EPC, rd);
        checks++; if (rd !== 32'hBFC0_2000) begin errors++; $display("FAIL eret_drop got %h exp bfc02000", rd); end
    endtask

    task automatic test_count();
        mtc0(CP0_COUNT, 32'hFFFF_FFFF);
        @(negedge clk);
        mfc0(CP0_COUNT, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cnt_load got %h exp ffffffff", rd); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        mfc0(CP0_COUNT, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cnt_wrap got %h exp 0", rd); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        mfc0(CP0_COUNT, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL cnt_inc got %h exp 1", rd); end
    endtask

    task automatic test_timer();
`ifdef CP0_TIMER_INT_EN
        mtc0(CP0_COMPARE, 32'd10);
        mtc0(CP0_COUNT, 32'd8);
        repeat (4) @(posedge clk);
        @(negedge clk);
        mfc0(CP0_COUNT, rd);
        checks++; if (rd !== 32'd10) begin errors++; $display("FAIL tmr_count got %h exp 0000000a", rd); end
        mfc0(CP0_CAUSE, rd);
        checks++; if (rd[30] !== 1'b0) begin errors++; $display("FAIL tmr_early got %0h exp 0", rd[30]); end
        @(posedge clk);
        @(negedge clk);
        mfc0(CP0_CAUSE, rd);
        checks++; if (rd[30] !== 1'b1 || rd[15] !== 1'b1) begin errors++; $display("FAIL tmr_set got ti=%0h ip7=%0h exp 1 1", rd[30], rd[15]); end
        mtc0(CP0_COMPARE, 32'd10);
        @(negedge clk);
        mfc0(CP0_CAUSE, rd);
        checks++; if (rd[30] !== 1'b0) begin errors++; $display("FAIL tmr_clear got %0h exp 0", rd[30]); end
`else
        mtc0(CP0_COMPARE, 32'd10);
        @(negedge clk);
        mfc0(CP0_COMPARE, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL tmr_cmp_absent got %h exp 0", rd); end
        mtc0(CP0_COUNT, 32'd8);
        repeat (8) @(posedge clk);
        @(negedge clk);
        mfc0(CP0_CAUSE, rd);
        checks++; if (rd[30] !== 1'b0) begin errors++; $display("FAIL tmr_never got %0h exp 0", rd[30]); end
`endif
    endtask

    task automatic test_reset_mid();
        mtc0(CP0_EPC, 32'h1234_5678);
        @(negedge clk);
        rst = 1'b1;
        slot_valid = 2'b01; slot_exc = 2'b01; slot_code = {5'd0, EXC_RI};
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rmid_flush got %0h exp 0", flush); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_slots();
        mfc0(CP0_EPC, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmid_epc got %h exp 0", rd); end
        mfc0(CP0_STATUS, rd);
        checks++; if (rd !== 32'h0040_0000) begin errors++; $display("FAIL rmid_status got %h exp 00400000", rd); end
        mfc0(CP0_COUNT, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmid_count got %h exp 0", rd); end
    endtask

    initial begin
        test_reset();
        test_oldest_exc();
        test_adel_ds();
        test_mtc0();
        test_interrupt();
        test_eret();
        test_count();
        test_timer();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
